id_ex_hazard_ctrl: RTL and testbench

//   Pipeline hazard controller for the IF/ID and ID/EX registers. It detects RAW

---
 rtl/id_ex_hazard_ctrl.sv | 155 +++++++++++++++
 tb/tb_id_ex_hazard_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_hazard_ctrl.sv
// id_ex_hazard_ctrl: stall/bubble/hold/kill sequencing for the IF/ID and ID/EX
// pipeline registers.
//   - RAW hazard detection between decode and EX/MEM.
//   - Multi-cycle EX op sequencing.
//   - Taken-branch kill window.
// Build option HAZ_FWD_EN:
//   - defined: a forwarding network exists, so only load-use stalls.
//   - undefined: any RAW dependence on EX or MEM stalls.
//
// state | meaning
// RUN   | normal issue; branch, multi-cycle start and hazard are resolved here
// BUSY  | multi-cycle op occupies EX; front end and ID/EX are frozen
// FLUSH | extra kill cycles after a taken branch
module id_ex_hazard_ctrl #(
    parameter int MC_CYCLES    = 4,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic       ex_valid,
    input  logic [4:0] ex_rd,
    input  logic       ex_is_load,
    input  logic       ex_mc_start,
    input  logic       branch_taken,
    input  logic       mem_valid,
    input  logic [4:0] mem_rd,
    output logic       pc_stall,
    output logic       if_id_stall,
    output logic       id_ex_bubble,
    output logic       id_ex_hold,
    output logic       branch_kill_flag,
    output logic       ex_busy
);

    typedef enum logic [1:0] {RUN, BUSY, FLUSH} state_t;

    // The RUN entry cycle already holds, so BUSY covers the remaining
    // MC_CYCLES-2 cycles of the MC_CYCLES-1 total hold window.
    localparam logic [3:0] MC_LOAD = 4'((MC_CYCLES > 2) ? (MC_CYCLES - 3) : 0);
    localparam logic [3:0] FL_LOAD = 4'((FLUSH_CYCLES > 1) ? (FLUSH_CYCLES - 2) : 0);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       match_ex;
    logic       hazard;
    logic       br_take;
    logic       mc_take;

    assign match_ex = ex_valid & (ex_rd != 5'd0) & id_valid &
                      ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                       (id_uses_rs2 & (id_rs2 == ex_rd)));

`ifdef HAZ_FWD_EN
    logic unused_mem;
    assign unused_mem = ^{mem_valid, mem_rd};
    assign hazard     = match_ex & ex_is_load;
`else
    logic match_mem;
    logic unused_load;
    assign unused_load = ex_is_load;
    assign match_mem   = mem_valid & (mem_rd != 5'd0) & id_valid &
                         ((id_uses_rs1 & (id_rs1 == mem_rd)) |
                          (id_uses_rs2 & (id_rs2 == mem_rd)));
    assign hazard      = match_ex | match_mem;
`endif

    assign br_take = branch_taken & ex_valid;
    assign mc_take = ex_mc_start & ex_valid;

    // State and down-counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and combinational outputs; reset forces all outputs low.
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        pc_stall         = 1'b0;
        if_id_stall      = 1'b0;
        id_ex_bubble     = 1'b0;
        id_ex_hold       = 1'b0;
        branch_kill_flag = 1'b0;
        ex_busy          = 1'b0;
        case (state_q)
            RUN: begin
                if (br_take) begin
                    branch_kill_flag = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = FLUSH;
                        cnt_d   = FL_LOAD;
                    end
                end else if (mc_take) begin
                    pc_stall    = 1'b1;
                    if_id_stall = 1'b1;
                    id_ex_hold  = 1'b1;
                    ex_busy     = 1'b1;
                    if (MC_CYCLES > 2) begin
                        state_d = BUSY;
                        cnt_d   = MC_LOAD;
                    end
                end else if (hazard) begin
                    pc_stall     = 1'b1;
                    if_id_stall  = 1'b1;
                    id_ex_bubble = 1'b1;
                end
            end
            BUSY: begin
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
                id_ex_hold  = 1'b1;
                ex_busy     = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            FLUSH: begin
                branch_kill_flag = 1'b1;
                if (br_take) begin
                    cnt_d = FL_LOAD;
                end else if (cnt_q == 4'd0) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = 4'd0;
            end
        endcase
        if (reset) begin
            pc_stall         = 1'b0;
            if_id_stall      = 1'b0;
            id_ex_bubble     = 1'b0;
            id_ex_hold       = 1'b0;
            branch_kill_flag = 1'b0;
            ex_busy          = 1'b0;
        end
    end

endmodule

// File: tb/tb_id_ex_hazard_ctrl.sv
// Bench for id_ex_hazard_ctrl: directed literal cases followed by random traffic,
// with a cycle-level reference model tracking remaining busy/kill cycles.
module tb_id_ex_hazard_ctrl;

    localparam int MC = 4;
    localparam int FC = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid, id_uses_rs1, id_uses_rs2;
    logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd;
    logic       ex_valid, ex_is_load, ex_mc_start, branch_taken, mem_valid;
    logic       pc_stall, if_id_stall, id_ex_bubble, id_ex_hold, branch_kill_flag, ex_busy;

    int checks = 0;
    int errors = 0;

    id_ex_hazard_ctrl #(.MC_CYCLES(MC), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_is_load(ex_is_load),
        .ex_mc_start(ex_mc_start), .branch_taken(branch_taken),
        .mem_valid(mem_valid), .mem_rd(mem_rd),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_bubble(id_ex_bubble),
        .id_ex_hold(id_ex_hold), .branch_kill_flag(branch_kill_flag), .ex_busy(ex_busy)
    );

    always #5 clk = ~clk;

    // {pc_stall, if_id_stall, id_ex_bubble, id_ex_hold, branch_kill_flag, ex_busy}
    localparam logic [5:0] O_NONE  = 6'b000000;
    localparam logic [5:0] O_HAZ   = 6'b111000;
    localparam logic [5:0] O_BUSY  = 6'b110101;
    localparam logic [5:0] O_KILL  = 6'b000010;

    function automatic logic [5:0] outs();
        return {pc_stall, if_id_stall, id_ex_bubble, id_ex_hold, branch_kill_flag, ex_busy};
    endfunction

    function automatic logic dep(input logic v, input logic [4:0] rd);
        return v && rd != 5'd0 && id_valid &&
               ((id_uses_rs1 && id_rs1 == rd) || (id_uses_rs2 && id_rs2 == rd));
    endfunction

    function automatic logic model_hazard();
`ifdef HAZ_FWD_EN
        return dep(ex_valid, ex_rd) && ex_is_load;
`else
        return dep(ex_valid, ex_rd) || dep(mem_valid, mem_rd);
`endif
    endfunction

    task automatic chk(input string name, input logic [5:0] got, input logic [5:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: remaining kill / busy cycles after the current one.
    int kill_rem = 0;
    int busy_rem = 0;
    logic [5:0] m_exp;
    logic m_br, m_mc;
    always @(negedge clk) begin
        m_exp = O_NONE;
        m_br  = branch_taken && ex_valid;
        m_mc  = ex_mc_start && ex_valid;
        if (reset) begin
            kill_rem = 0;
            busy_rem = 0;
        end else if (kill_rem > 0) begin
            m_exp    = O_KILL;
            kill_rem = m_br ? FC - 1 : kill_rem - 1;
        end else if (busy_rem > 0) begin
            m_exp    = O_BUSY;
            busy_rem = busy_rem - 1;
        end else if (m_br) begin
            m_exp    = O_KILL;
            kill_rem = FC - 1;
        end else if (m_mc) begin
            m_exp    = O_BUSY;
            busy_rem = MC - 2;
        end else if (model_hazard()) begin
            m_exp = O_HAZ;
        end
        chk("model", outs(), m_exp);
    end

    task automatic idle();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        ex_valid = 0; ex_rd = 0; ex_is_load = 0; ex_mc_start = 0; branch_taken = 0;
        mem_valid = 0; mem_rd = 0;
    endtask

    // Check outputs mid-cycle, then advance to just after the next rising edge.
    task automatic cyc(input string name, input logic [5:0] exp);
        @(negedge clk);
        #1 chk(name, outs(), exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1 chk("reset_outs", outs(), O_NONE);
        reset = 1'b0;
        cyc("idle", O_NONE);

        // Multi-cycle op: 3 hold cycles, branch inside BUSY ignored.
        ex_valid = 1; ex_mc_start = 1; ex_rd = 5'd3;
        cyc("mc_entry", O_BUSY);
        ex_mc_start = 0; branch_taken = 1;
        cyc("mc_busy_br", O_BUSY);
        branch_taken = 0;
        cyc("mc_busy_last", O_BUSY);
        idle();
        cyc("mc_done", O_NONE);

        // Reset in the middle of BUSY.
        ex_valid = 1; ex_mc_start = 1;
        cyc("mc_entry2", O_BUSY);
        ex_mc_start = 0;
        #2 reset = 1'b1;
        #1 chk("rst_mid_busy", outs(), O_NONE);
        @(posedge clk);
        #1 reset = 1'b0;
        idle();
        cyc("rst_release", O_NONE);
        cyc("rst_stay_run", O_NONE);

`ifdef HAZ_FWD_EN
        ex_valid = 1; ex_rd = 5'd5; ex_is_load = 1;
        id_valid = 1; id_rs1 = 5'd5; id_uses_rs1 = 1;
        cyc("load_use", O_HAZ);
        ex_valid = 0; ex_is_load = 0; mem_valid = 1; mem_rd = 5'd5;
        cyc("load_use_done", O_NONE);
        ex_valid = 1; ex_rd = 5'd0; ex_is_load = 1; id_rs1 = 5'd0; mem_valid = 0;
        cyc("load_x0", O_NONE);
        idle();
`else
        ex_valid = 1; ex_rd = 5'd7;
        id_valid = 1; id_rs2 = 5'd7; id_uses_rs2 = 1;
        cyc("raw_ex", O_HAZ);
        ex_valid = 0; mem_valid = 1; mem_rd = 5'd7;
        cyc("raw_mem", O_HAZ);
        mem_valid = 0;
        cyc("raw_done", O_NONE);
        ex_valid = 1; ex_rd = 5'd0; id_rs2 = 5'd0;
        cyc("raw_x0", O_NONE);
        idle();
`endif

        // Taken branch over a load-use hazard, then re-armed by a second branch.
        ex_valid = 1; branch_taken = 1; ex_is_load = 1; ex_rd = 5'd5;
        id_valid = 1; id_rs1 = 5'd5; id_uses_rs1 = 1;
        cyc("br_kill", O_KILL);
        cyc("br_rearm", O_KILL);
        branch_taken = 0;
        cyc("br_extend", O_KILL);
        idle();
        cyc("br_done", O_NONE);

        // Branch and multi-cycle start together: branch wins.
        ex_valid = 1; branch_taken = 1; ex_mc_start = 1;
        cyc("br_mc", O_KILL);
        idle();
        cyc("br_mc_flush", O_KILL);
        cyc("br_mc_done", O_NONE);

        // Random traffic; the model process checks every cycle.
        for (int i = 0; i < 3000; i++) begin
            reset        = ($urandom_range(0, 99) < 2);
            id_valid     = ($urandom_range(0, 9) < 8);
            id_rs1       = 5'($urandom_range(0, 3));
            id_rs2       = 5'($urandom_range(0, 3));
            id_uses_rs1  = $urandom_range(0, 1);
            id_uses_rs2  = $urandom_range(0, 1);
            ex_valid     = ($urandom_range(0, 9) < 7);
            ex_rd        = 5'($urandom_range(0, 3));
            ex_is_load   = $urandom_range(0, 1);
            ex_mc_start  = ($urandom_range(0, 99) < 10);
            branch_taken = ($urandom_range(0, 99) < 10);
            mem_valid    = ($urandom_range(0, 9) < 7);
            mem_rd       = 5'($urandom_range(0, 3));
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        idle();
        repeat (4) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
